// File: rtl/queue_button_ctrl_pkg.sv
// rtl/queue_button_ctrl_pkg.sv - shared queue sizing defaults for queue_button_ctrl and its bench
package queue_button_ctrl_pkg;

    localparam int QUEUE_DATA_W = 4;   // switch bank width
    localparam int QUEUE_ADDR_W = 2;   // pointer width

    // DEPTH = 2**ADDR_W; count needs one extra bit to represent DEPTH itself
    function automatic int queue_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int queue_count_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/queue_button_ctrl_reg_file.sv
// rtl/queue_button_ctrl_reg_file.sv - DEPTH x DATA_W storage, one sync write port, one async read port
//
// Ports:
//   clk    system clock, write on rising edge
//   we     write enable
//   waddr  write address (wr_ptr)
//   wdata  write data
//   raddr  read address (rd_ptr)
//   rdata  combinational read data
// Contents are not reset; the controller masks them while the queue is empty.
module queue_reg_file
    import queue_button_ctrl_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int ADDR_W = QUEUE_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/queue_button_ctrl.sv
// rtl/queue_button_ctrl.sv - circular queue core driven by push/pop button pulses
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   push_bt    push request pulse
//   pop_bt     pop request pulse
//   sw_data    value written on an accepted push
//   head_data  registered oldest entry, 0 when empty (one cycle behind the queue state)
//   count      registered occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   err        sticky flag for the last rejected request
// Build option QUEUE_EDGE_GUARD_EN: push_bt/pop_bt go through registered
// rising-edge detectors, so a held level is one request (+1 cycle latency).
module queue_button_ctrl
    import queue_button_ctrl_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int ADDR_W = QUEUE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_bt,
    input  logic              pop_bt,
    input  logic [DATA_W-1:0] sw_data,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(queue_depth(ADDR_W));

    logic push_req;
    logic pop_req;

`ifdef QUEUE_EDGE_GUARD_EN
    logic push_prev;
    logic pop_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_prev <= 1'b0;
            pop_prev  <= 1'b0;
            push_req  <= 1'b0;
            pop_req   <= 1'b0;
        end else begin
            push_prev <= push_bt;
            pop_prev  <= pop_bt;
            push_req  <= push_bt & ~push_prev;
            pop_req   <= pop_bt & ~pop_prev;
        end
    end
`else
    assign push_req = push_bt;
    assign pop_req  = pop_bt;
`endif

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;

    logic              push_acc;
    logic              pop_acc;
    logic              err_next;
    logic [ADDR_W:0]   count_next;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    always_comb begin
        push_acc   = 1'b0;
        pop_acc    = 1'b0;
        err_next   = err;
        count_next = count;

        pop_acc  = pop_req && !empty;
        // A pop in the same cycle frees the slot, so push at full is still taken
        push_acc = push_req && (!full || pop_req);

        if ((push_req && !push_acc) || (pop_req && !pop_acc && !push_req)) begin
            err_next = 1'b1;
        end else if (push_acc && pop_req && !pop_acc) begin
            // push+pop on an empty queue: the ignored pop leaves err as it was
            err_next = err;
        end else if (push_acc || pop_acc) begin
            err_next = 1'b0;
        end

        if (push_acc && !pop_acc) begin
            count_next = count + 1'b1;
        end else if (pop_acc && !push_acc) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
            head_data <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            err   <= err_next;
            // Registered view of the current head: trails the queue state by one cycle
            head_data <= empty ? '0 : rd_data;
        end
    end

    queue_reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (sw_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
